byte_mem_responder: RTL and testbench
=====================================

# byte_mem_responder

Memory-side responder for the processor's multicycle FSM memory port. It accepts one request at a time (fetch, load or store), checks alignment and range, and services it against four 8-bit byte-lane banks. It returns read data big-endian: the lowest address maps to bits 31:24. It signals completion with a one-cycle `done` pulse and faults with `error`.

## Interface
Parameters:
- ADDR_BITS, 12: byte-address width implemented; capacity 2^ADDR_BITS bytes.
- WORD_SIZE, 32: data width; fixed at 4 lanes × 8 bits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req  in  1  request strobe; sampled only in IDLE.
- address  in  32  byte address.
- write  in  2  operation: 00 read word, 01 store byte, 10 store halfword, 11 store word.
- wdata  in  32  store data; byte store uses [7:0], halfword store uses [15:0].
- rdata  out  32  read data; holds its value until the next read completes.
- done  out  1  one-cycle completion pulse.
- error  out  1  fault; one-cycle pulse coincident with `done`.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE → ACCESS when `req`=1.
  - `address`, `write` and `wdata` are latched.
  - Alignment is checked at the same time.
- Alignment/range fault when any of these hold:
  - halfword store with address[0]=1;
  - word store with address[1:0]≠00;
  - any request with address[31:ADDR_BITS]≠0.
- Reads never fault on alignment. They return the aligned word at address[ADDR_BITS-1:2].
- On a fault, no bank is written and the flow goes IDLE → RESP directly, with `error`=1, `done`=1, and `rdata` unchanged.
- ACCESS:
  - Stores: assert the lane write enables on this cycle's edge.
    - Byte store: lane = address[1:0], where lane 0 = bits 31:24.
    - Halfword store: lanes {address[1],0} and {address[1],1}; wdata[15:8] goes to the lower address.
    - Word store: all lanes; wdata[31:24] goes to lane 0.
  - Reads: the banks register the word on this edge.
  - ACCESS → RESP.
- RESP:
  - Reads: `rdata` ← {q0,q1,q2,q3}.
  - `done`=1 for this cycle only.
  - RESP → IDLE.
- A `req` that arrives while `busy`=1 is ignored; it is neither queued nor flagged.
- Reset mid-operation: the FSM returns to IDLE asynchronously. A store whose ACCESS edge has not occurred is dropped. Bank contents are not cleared by reset.

## Timing
- Reset values: `rdata`=0, `done`=0, `error`=0, `busy`=0, state IDLE.
- Accepted at edge E0 (req=1 in IDLE):
  - read/store: ACCESS during E0–E1, RESP during E1–E2; `done` and `rdata` valid after E1. Latency is 2 cycles from the `req` sample to the `done` edge.
  - fault: RESP during E0–E1; `error` and `done` valid after E0. Latency is 1 cycle.
- Minimum request spacing is 3 cycles: the next `req` is accepted at the edge that ends RESP and returns to IDLE, at the earliest one cycle later.
- Store data is visible to a read accepted in the cycle after `done`.
- Banks: synchronous write, synchronous read, read-before-write.

## Structure
- Shared package (`mem_pkg`):
  - state encoding;
  - write-code constants: WR_READ, WR_BYTE, WR_HALF, WR_WORD;
  - lane-count constant: 4.
- Sub-module `byte_lane_bank`:
  - one 8-bit × 2^(ADDR_BITS-2) synchronous RAM with ports clk, we, addr, d, q;
  - instantiated four times, once per lane.
- Top level contains: FSM, request latch, alignment/range check, lane-enable decode, output register.

## Test plan
- Word store then read: store 0xDEADBEEF at 0x010, then read 0x010 → `done` two cycles after each `req`; `rdata`=0xDEADBEEF; `error`=0.
- Byte store: store wdata=0x000000AA at 0x013, then read 0x010 → `rdata`=0xDEADBEAA.
- Halfword store: store wdata=0x00001234 at 0x012, then read 0x011 (unaligned read allowed) → `rdata`=0xDEAD1234.
- Misaligned faults:
  - word store at 0x006 → `error`=1 and `done`=1 one cycle after `req`;
  - a subsequent read of 0x004 shows the bank unchanged;
  - halfword store at 0x001 → `error`=1.
- Range fault and ignored req:
  - read at 0x1000 (ADDR_BITS=12) → `error`=1;
  - a `req` asserted during ACCESS is ignored → exactly one `done` pulse.
- Reset mid-store: word store of 0x11111111 to 0x020 over existing 0x22222222, with `rst` pulsed low before the ACCESS edge → all outputs return to 0; a later read of 0x020 returns 0x22222222.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the byte-lane memory responder.
// Contents:
//   state_t            - responder FSM state encoding
//   WR_READ..WR_WORD   - operation codes carried on the 'write' port
//   LANES              - number of 8-bit byte lanes in a word
//   lane_enable()      - per-lane write enables for a store code and address[1:0]
//   lane_byte()        - byte routed to a given lane for a store code
// Lane 0 holds the lowest byte address, which is bits 31:24 of a word.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    localparam logic [1:0] WR_READ = 2'b00;
    localparam logic [1:0] WR_BYTE = 2'b01;
    localparam logic [1:0] WR_HALF = 2'b10;
    localparam logic [1:0] WR_WORD = 2'b11;

    localparam int LANES = 4;

    // Bit i of the result enables lane i.
    function automatic logic [3:0] lane_enable(input logic [1:0] code, input logic [1:0] lo);
        logic [3:0] en;
        logic [1:0] li;
        en = 4'b0000;
        for (int i = 0; i < LANES; i++) begin
            li = 2'(i);
            case (code)
                WR_BYTE: en[i] = (li == lo);
                WR_HALF: en[i] = (li[1] == lo[1]);
                WR_WORD: en[i] = 1'b1;
                default: en[i] = 1'b0;
            endcase
        end
        return en;
    endfunction

    // Big-endian routing: the lower address of a halfword takes wdata[15:8],
    // lane 0 of a word takes wdata[31:24].
    function automatic logic [7:0] lane_byte(input logic [1:0] code, input logic [1:0] lane,
                                             input logic [31:0] wd);
        logic [7:0] b;
        b = wd[7:0];
        case (code)
            WR_WORD: begin
                case (lane)
                    2'd0:    b = wd[31:24];
                    2'd1:    b = wd[23:16];
                    2'd2:    b = wd[15:8];
                    default: b = wd[7:0];
                endcase
            end
            WR_HALF: begin
                if (lane[0]) begin
                    b = wd[7:0];
                end else begin
                    b = wd[15:8];
                end
            end
            default: b = wd[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/byte_lane_bank.sv
// One 8-bit byte lane of the responder's memory.
// Ports:
//   clk   in   clock
//   we    in   write enable (synchronous)
//   addr  in   word address
//   d     in   write data
//   q     out  registered read data (read-before-write on a same-cycle write)
// Contents are deliberately not reset.
module byte_lane_bank #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    d,
    output logic [7:0]    q
);

    logic [7:0] mem_r [0:(1<<AW)-1];

    // Synchronous read of the old contents and optional write.
    always_ff @(posedge clk) begin
        q <= mem_r[addr];
        if (we) begin
            mem_r[addr] <= d;
        end
    end

endmodule

// File: rtl/byte_mem_responder.sv
// Memory-side responder for a multicycle processor memory port.
// Accepts one request at a time, checks alignment and range, and services it
// against four byte-lane banks. Read data is big-endian (lowest address in 31:24).
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-low reset
//   req      in   request strobe, sampled only when idle
//   address  in   byte address
//   write    in   00 read word, 01 store byte, 10 store halfword, 11 store word
//   wdata    in   store data
//   rdata    out  read data, held until the next read completes
//   done     out  one-cycle completion pulse
//   error    out  fault pulse, coincident with done
//   busy     out  high whenever not idle
module byte_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_BITS = 12,
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic [31:0]          address,
    input  logic [1:0]           write,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 done,
    output logic                 error,
    output logic                 busy
);

    localparam int WAW = ADDR_BITS - 2;

    state_t                 state_r;
    logic [ADDR_BITS-1:0]   addr_r;
    logic [1:0]             write_r;
    logic [WORD_SIZE-1:0]   wdata_r;
    logic                   fault_s;
    logic [WAW-1:0]         bank_addr_s;
    logic [3:0]             lane_we_s;
    logic [7:0]             lane_d_s [LANES];
    logic [7:0]             lane_q_s [LANES];

    // Alignment and range check on the incoming request.
    always_comb begin
        fault_s = 1'b0;
        if ((address >> ADDR_BITS) != 32'd0) begin
            fault_s = 1'b1;
        end else if (write == WR_HALF && address[0]) begin
            fault_s = 1'b1;
        end else if (write == WR_WORD && address[1:0] != 2'b00) begin
            fault_s = 1'b1;
        end else begin
            fault_s = 1'b0;
        end
    end

    // While idle the banks look up the incoming address so the word is ready
    // one edge early; the ACCESS edge re-reads the same latched word.
    always_comb begin
        bank_addr_s = addr_r[ADDR_BITS-1:2];
        if (state_r == ST_IDLE) begin
            bank_addr_s = address[ADDR_BITS-1:2];
        end else begin
            bank_addr_s = addr_r[ADDR_BITS-1:2];
        end
    end

    // Lane write enables fire only on the ACCESS edge; faults never reach ACCESS.
    always_comb begin
        lane_we_s = 4'b0000;
        if (state_r == ST_ACCESS) begin
            lane_we_s = lane_enable(write_r, addr_r[1:0]);
        end else begin
            lane_we_s = 4'b0000;
        end
    end

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            assign lane_d_s[g] = lane_byte(write_r, 2'(g), wdata_r);

            byte_lane_bank #(.AW(WAW)) u_bank (
                .clk  (clk),
                .we   (lane_we_s[g]),
                .addr (bank_addr_s),
                .d    (lane_d_s[g]),
                .q    (lane_q_s[g])
            );
        end
    endgenerate

    // Request FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            addr_r  <= '0;
            write_r <= 2'b00;
            wdata_r <= '0;
            rdata   <= '0;
            done    <= 1'b0;
            error   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req) begin
                        addr_r  <= address[ADDR_BITS-1:0];
                        write_r <= write;
                        wdata_r <= wdata;
                        busy    <= 1'b1;
                        if (fault_s) begin
                            state_r <= ST_RESP;
                            done    <= 1'b1;
                            error   <= 1'b1;
                        end else begin
                            state_r <= ST_ACCESS;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    state_r <= ST_RESP;
                    done    <= 1'b1;
                    busy    <= 1'b1;
                    if (write_r == WR_READ) begin
                        rdata <= {lane_q_s[0], lane_q_s[1], lane_q_s[2], lane_q_s[3]};
                    end else begin
                        rdata <= rdata;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_mem_responder.sv
// Directed, table-driven bench for byte_mem_responder, plus hand-written
// sequences for the ignored-request and reset-during-store cases.
module tb_byte_mem_responder;

    logic        clk;
    logic        rst;
    logic        req;
    logic [31:0] address;
    logic [1:0]  write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        error;
    logic        busy;

    int n_vec;
    int n_bad;

    typedef struct {
        logic [1:0]  code;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [19];

    byte_mem_responder #(.ADDR_BITS(12), .WORD_SIZE(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .address (address),
        .write   (write),
        .wdata   (wdata),
        .rdata   (rdata),
        .done    (done),
        .error   (error),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_req(input int idx, input vec_t v);
        int lat;
        @(negedge clk);
        req     = 1'b1;
        write   = v.code;
        address = v.addr;
        wdata   = v.wd;
        @(posedge clk);
        #1;
        req = 1'b0;
        lat = 1;
        while (!done && lat < 6) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) begin
            $display("FAIL done_timeout: vector %0d got no done want done", idx);
            n_vec++;
            n_bad++;
        end else begin
            check($sformatf("latency[%0d]", idx), 32'(lat), v.err ? 32'd1 : 32'd2);
            check($sformatf("error[%0d]", idx), {31'd0, error}, {31'd0, v.err});
            check($sformatf("rdata[%0d]", idx), rdata, v.rd);
            check($sformatf("busy_at_done[%0d]", idx), {31'd0, busy}, 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("done_pulse[%0d]", idx), {31'd0, done}, 32'd0);
            check($sformatf("busy_idle[%0d]", idx), {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        int pulses;
        n_vec   = 0;
        n_bad   = 0;
        rst     = 1'b0;
        req     = 1'b0;
        address = 32'd0;
        write   = 2'b00;
        wdata   = 32'd0;

        //        code   address         wdata          err   expected rdata
        vecs[0]  = '{2'b11, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{2'b00, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{2'b01, 32'h0000_0013, 32'h0000_00AA, 1'b0, 32'hDEAD_BEEF};
        vecs[3]  = '{2'b00, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEAA};
        vecs[4]  = '{2'b10, 32'h0000_0012, 32'h0000_1234, 1'b0, 32'hDEAD_BEAA};
        vecs[5]  = '{2'b00, 32'h0000_0011, 32'h0000_0000, 1'b0, 32'hDEAD_1234};
        vecs[6]  = '{2'b11, 32'h0000_0004, 32'h5566_7788, 1'b0, 32'hDEAD_1234};
        vecs[7]  = '{2'b11, 32'h0000_0006, 32'h9999_9999, 1'b1, 32'hDEAD_1234};
        vecs[8]  = '{2'b00, 32'h0000_0004, 32'h0000_0000, 1'b0, 32'h5566_7788};
        vecs[9]  = '{2'b10, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 32'h5566_7788};
        vecs[10] = '{2'b00, 32'h0000_1000, 32'h0000_0000, 1'b1, 32'h5566_7788};
        vecs[11] = '{2'b11, 32'h0000_000C, 32'h0102_0304, 1'b0, 32'h5566_7788};
        vecs[12] = '{2'b10, 32'h0000_000C, 32'hFFFF_ABCD, 1'b0, 32'h5566_7788};
        vecs[13] = '{2'b01, 32'h0000_000E, 32'hEEEE_EE77, 1'b0, 32'h5566_7788};
        vecs[14] = '{2'b00, 32'h0000_000F, 32'h0000_0000, 1'b0, 32'hABCD_7704};
        vecs[15] = '{2'b10, 32'h0000_0003, 32'h0000_5555, 1'b1, 32'hABCD_7704};
        vecs[16] = '{2'b11, 32'h8000_0000, 32'h0BAD_0BAD, 1'b1, 32'hABCD_7704};
        vecs[17] = '{2'b11, 32'h0000_0020, 32'h2222_2222, 1'b0, 32'hABCD_7704};
        vecs[18] = '{2'b00, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h2222_2222};

        #12;
        check("reset_rdata", rdata, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_error", {31'd0, error}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 19; i++) begin
            do_req(i, vecs[i]);
        end

        // Word at 0x010 now holds 0xDEAD1234; a req held into ACCESS with a
        // different address must not start a second transaction.
        @(negedge clk);
        req     = 1'b1;
        write   = 2'b00;
        address = 32'h0000_0010;
        @(posedge clk);
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                address = 32'h0000_0004;
            end
            if (c == 1) begin
                req = 1'b0;
            end
            if (done) begin
                pulses++;
            end
        end
        check("ignored_req_pulses", 32'(pulses), 32'd1);
        check("ignored_req_rdata", rdata, 32'hDEAD_1234);

        // Reset between acceptance and the ACCESS edge drops the store.
        @(negedge clk);
        req     = 1'b1;
        write   = 2'b11;
        address = 32'h0000_0020;
        wdata   = 32'h1111_1111;
        @(posedge clk);
        #1;
        req = 1'b0;
        check("busy_before_reset", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("midreset_rdata", rdata, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_error", {31'd0, error}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        do_req(99, '{2'b00, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h2222_2222});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
